// File: rtl/uart_passthru_sniffer_if.sv
// Output bundle of the UART sniffer: decoded byte, strobes, break level,
// LED activity and received-byte counter. The sniffer drives it through the
// master modport, and consumers read it through the slave modport.
interface uart_passthru_sniffer_if #(
  parameter int C_count_width = 16
);
  logic [7:0]               data;
  logic                     data_valid;
  logic                     frame_err;
  logic                     break_det;
  logic                     activity;
  logic [C_count_width-1:0] byte_count;

  modport master (
    output data, data_valid, frame_err, break_det, activity, byte_count
  );

  modport slave (
    input data, data_valid, frame_err, break_det, activity, byte_count
  );
endinterface

// File: rtl/uart_passthru_sniffer.sv
// Passive 8N1 UART sniffer for one line of the FTDI<->ESP32 passthrough.
// It only watches the line and never drives it. It decodes bytes, flags
// framing errors, counts good bytes and stretches an activity pulse for an LED.
// Optional macro SNIFFER_BREAK_EN: when defined, break_det reports a line break
// (all-zero frame with a low stop bit) until the line returns high. When the
// macro is undefined, break_det is tied low.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line high, waiting for a falling edge
// START      | half-bit wait, then confirm the start bit is still low
// DATA       | sample 8 data bits LSB-first at mid-bit
// STOP       | sample the stop bit, then emit the byte or a framing error
// WAIT_HIGH  | after a framing error, wait for the line to return high
module uart_passthru_sniffer #(
  parameter int C_clk_div     = 217,
  parameter int C_act_bits    = 21,
  parameter int C_count_width = 16
) (
  input  logic                    clk_25mhz,
  input  logic                    reset,
  input  logic                    rxd_in,
  uart_passthru_sniffer_if.master mon
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  // Full-bit reload, and half-bit reload that centres sampling in each bit.
  localparam logic [15:0] C_full = 16'(C_clk_div - 1);
  localparam logic [15:0] C_half = 16'(C_clk_div / 2 - 1);

  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_s_q, rx_s_d;
  logic [2:0]               state_q, state_d;
  logic [15:0]              timer_q, timer_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;
  logic [7:0]               data_q, data_d;
  logic                     dv_q, dv_d;
  logic                     fe_q, fe_d;
  logic [C_act_bits-1:0]    act_q, act_d;
  logic [C_count_width-1:0] count_q, count_d;
`ifdef SNIFFER_BREAK_EN
  logic                     brk_q, brk_d;
`endif

  // Next-state logic: synchronizer inputs, frame FSM, activity stretcher.
  always_comb begin
    rx_meta_d = rxd_in;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    count_d   = count_q;
    act_d     = (act_q != '0) ? act_q - C_act_bits'(1) : act_q;
`ifdef SNIFFER_BREAK_EN
    brk_d     = brk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          timer_d = C_half;
        end
      end
      S_START: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else if (!rx_s_q) begin
          state_d   = S_DATA;
          timer_d   = C_full;
          bit_idx_d = 3'd0;
          act_d     = '1;
        end else begin
          // Start bit was a glitch, so drop it without touching any output.
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = C_full;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else if (rx_s_q) begin
          data_d  = shift_q;
          dv_d    = 1'b1;
          count_d = count_q + C_count_width'(1);
          state_d = S_IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = S_WAIT_HIGH;
`ifdef SNIFFER_BREAK_EN
          brk_d   = (shift_q == 8'h00);
`endif
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
`ifdef SNIFFER_BREAK_EN
          brk_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      act_q     <= '0;
      count_q   <= '0;
`ifdef SNIFFER_BREAK_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      act_q     <= act_d;
      count_q   <= count_d;
`ifdef SNIFFER_BREAK_EN
      brk_q     <= brk_d;
`endif
    end
  end

  assign mon.data       = data_q;
  assign mon.data_valid = dv_q;
  assign mon.frame_err  = fe_q;
  assign mon.activity   = (act_q != '0);
  assign mon.byte_count = count_q;
`ifdef SNIFFER_BREAK_EN
  assign mon.break_det  = brk_q;
`else
  assign mon.break_det  = 1'b0;
`endif

endmodule
